// File: rtl/win_pkg.sv
// Shared definitions for the window read controller and the blocks that consume
// its addresses.
//   - win_state_t : controller state encoding (S_IDLE, S_ISSUE, S_DRAIN, S_DONE)
//   - WIN_*       : default window geometry, address width and read latency
package win_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_DRAIN = 2'd2,
        S_DONE  = 2'd3
    } win_state_t;

    localparam int WIN_ADR_W     = 8;
    localparam int WIN_COLS      = 10;
    localparam int WIN_ROWS      = 10;
    localparam int WIN_ROW_PITCH = 14;
    localparam int WIN_MEM_LAT   = 1;

endpackage

// File: rtl/win_lat_pipe.sv
// Read-latency tracker: a LAT-deep shift register carrying {vld,last} for every
// issued read, so that the tags line up with the data leaving pixel memory.
// Ports:
//   clk, rst            clock and synchronous active-high reset
//   clr                 synchronous flush (drops every read in flight)
//   in_vld, in_last     read issued this cycle / it is the last of the window
//   out_vld, out_last   same flags delayed by LAT cycles
module win_lat_pipe #(
    parameter int LAT = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic clr,
    input  logic in_vld,
    input  logic in_last,
    output logic out_vld,
    output logic out_last
);

    logic [LAT-1:0] vld_reg;
    logic [LAT-1:0] last_reg;
    logic [LAT-1:0] vld_next;
    logic [LAT-1:0] last_next;

    generate
        for (genvar gi = 0; gi < LAT; gi++) begin : g_stage
            if (gi == 0) begin : g_head
                assign vld_next[gi]  = in_vld;
                assign last_next[gi] = in_last;
            end else begin : g_tail
                assign vld_next[gi]  = vld_reg[gi-1];
                assign last_next[gi] = last_reg[gi-1];
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst || clr) begin
            vld_reg  <= '0;
            last_reg <= '0;
        end else begin
            vld_reg  <= vld_next;
            last_reg <= last_next;
        end
    end

    assign out_vld  = vld_reg[LAT-1];
    assign out_last = last_reg[LAT-1];

endmodule

// File: rtl/win_read_ctrl.sv
// Window read sequencer: reads one ROWS x COLS window from pixel memory in raster
// order (address = base + row*ROW_PITCH + col, modulo 2**ADR_W), tracks the memory
// read latency and tags the returned pixels, reporting completion to the layer
// controller.
// Ports:
//   clk, rst          clock, synchronous active-high reset
//   start, base_adr   begin a window at base_adr (accepted only when idle)
//   stall             hold off new reads; reads in flight still complete
//   abort             (only with WIN_CTRL_ABORT_EN) cancel the window, no done
//   mem_rd, mem_adr   read strobe / address to pixel memory
//   pix_vld, pix_last read data valid at the memory output / last pixel
//   busy, done        window in progress / one-cycle completion pulse
// Build option: define WIN_CTRL_ABORT_EN to add the abort input.
module win_read_ctrl
    import win_pkg::*;
#(
    parameter int ADR_W     = WIN_ADR_W,
    parameter int COLS      = WIN_COLS,
    parameter int ROWS      = WIN_ROWS,
    parameter int ROW_PITCH = WIN_ROW_PITCH,
    parameter int MEM_LAT   = WIN_MEM_LAT
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [ADR_W-1:0] base_adr,
    input  logic             stall,
`ifdef WIN_CTRL_ABORT_EN
    input  logic             abort,
`endif
    output logic             mem_rd,
    output logic [ADR_W-1:0] mem_adr,
    output logic             pix_vld,
    output logic             pix_last,
    output logic             busy,
    output logic             done
);

    // Counters keep at least one bit so a 1-wide window still elaborates.
    localparam int CW = (COLS > 1) ? $clog2(COLS) : 1;
    localparam int RW = (ROWS > 1) ? $clog2(ROWS) : 1;
    localparam logic [CW-1:0] COL_MAX = CW'(COLS - 1);
    localparam logic [RW-1:0] ROW_MAX = RW'(ROWS - 1);

    win_state_t       state_reg;
    logic [ADR_W-1:0] row_base_reg;
    logic [CW-1:0]    col_reg;
    logic [RW-1:0]    row_reg;

    logic last_pos;
    logic rd_issue;
    logic abort_req;

`ifdef WIN_CTRL_ABORT_EN
    // Abort only matters while a window is running.
    assign abort_req = abort && (state_reg != S_IDLE);
`else
    assign abort_req = 1'b0;
`endif

    assign last_pos = (row_reg == ROW_MAX) && (col_reg == COL_MAX);
    assign rd_issue = (state_reg == S_ISSUE) && !stall && !abort_req;

    assign mem_rd  = rd_issue;
    assign mem_adr = row_base_reg + ADR_W'(col_reg);
    assign busy    = (state_reg != S_IDLE);
    assign done    = (state_reg == S_DONE);

    always_ff @(posedge clk) begin
        if (rst || abort_req) begin
            state_reg    <= S_IDLE;
            row_base_reg <= '0;
            col_reg      <= '0;
            row_reg      <= '0;
        end else begin
            case (state_reg)
                S_IDLE: begin
                    if (start) begin
                        state_reg    <= S_ISSUE;
                        row_base_reg <= base_adr;
                        col_reg      <= '0;
                        row_reg      <= '0;
                    end
                end
                S_ISSUE: begin
                    if (!stall) begin
                        if (last_pos) begin
                            state_reg <= S_DRAIN;
                        end
                        if (col_reg == COL_MAX) begin
                            col_reg      <= '0;
                            row_reg      <= row_reg + RW'(1);
                            // Wraps modulo 2**ADR_W by construction.
                            row_base_reg <= row_base_reg + ADR_W'(ROW_PITCH);
                        end else begin
                            col_reg <= col_reg + CW'(1);
                        end
                    end
                end
                S_DRAIN: begin
                    if (pix_vld && pix_last) begin
                        state_reg <= S_DONE;
                    end
                end
                default: begin
                    state_reg <= S_IDLE;
                end
            endcase
        end
    end

    win_lat_pipe #(
        .LAT (MEM_LAT)
    ) u_lat_pipe (
        .clk      (clk),
        .rst      (rst),
        .clr      (abort_req),
        .in_vld   (rd_issue),
        .in_last  (rd_issue && last_pos),
        .out_vld  (pix_vld),
        .out_last (pix_last)
    );

endmodule

// File: tb/tb_win_read_ctrl.sv
// Self-checking bench for win_read_ctrl: random bases, stall patterns and stray
// start pulses, compared each cycle against a window model built from address
// arithmetic and a per-cycle record of which reads the model expects.
module tb_win_read_ctrl;
    import win_pkg::*;

    localparam int ADR_W     = WIN_ADR_W;
    localparam int COLS      = WIN_COLS;
    localparam int ROWS      = WIN_ROWS;
    localparam int ROW_PITCH = WIN_ROW_PITCH;
    localparam int LAT       = WIN_MEM_LAT;
    localparam int NPIX      = ROWS * COLS;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [ADR_W-1:0] base_adr;
    logic             stall;
`ifdef WIN_CTRL_ABORT_EN
    logic             abort;
`endif
    logic             mem_rd;
    logic [ADR_W-1:0] mem_adr;
    logic             pix_vld;
    logic             pix_last;
    logic             busy;
    logic             done;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    win_read_ctrl dut (
        .clk      (clk),
        .rst      (rst),
        .start    (start),
        .base_adr (base_adr),
        .stall    (stall),
`ifdef WIN_CTRL_ABORT_EN
        .abort    (abort),
`endif
        .mem_rd   (mem_rd),
        .mem_adr  (mem_adr),
        .pix_vld  (pix_vld),
        .pix_last (pix_last),
        .busy     (busy),
        .done     (done)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Several idle cycles: nothing may move, whatever stall does.
    task automatic idle_check(input int ncyc, input bit chk_adr, input string tag);
        for (int i = 0; i < ncyc; i++) begin
            @(negedge clk);
            start = 1'b0;
            stall = 1'($urandom_range(0, 1));
            #1;
            check_val({tag, "_busy"}, 32'(busy), 32'(0));
            check_val({tag, "_rd"}, 32'(mem_rd), 32'(0));
            check_val({tag, "_vld"}, 32'(pix_vld), 32'(0));
            check_val({tag, "_last"}, 32'(pix_last), 32'(0));
            check_val({tag, "_done"}, 32'(done), 32'(0));
            if (chk_adr) check_val({tag, "_adr"}, 32'(mem_adr), 32'(0));
        end
    endtask

    // stall_mode: 0 none, 1 every other cycle, 2 random ~25%.
    // cut_kind:   0 run to completion, 1 reset after cut_after reads, 2 abort.
    task automatic run_window(input logic [ADR_W-1:0] base, input int stall_mode,
                              input bit pulse_start, input int cut_after, input int cut_kind);
        logic [ADR_W-1:0] exp_adr[$];
        bit               rd_hist[$];
        int               idx_hist[$];
        int k = 0;
        int nstall = 0;
        int last_vld_cyc = -1;
        int limit = NPIX * 4 + LAT + 20;
        bit finished = 1'b0;
        bit exp_rd, exp_vld, exp_last, exp_done;
        int idx;

        for (int r = 0; r < ROWS; r++)
            for (int c = 0; c < COLS; c++)
                exp_adr.push_back(ADR_W'((int'(base) + r * ROW_PITCH + c) % (1 << ADR_W)));

        // Cycle 0: start presented while idle.
        @(negedge clk);
        start    = 1'b1;
        base_adr = base;
        stall    = 1'($urandom_range(0, 1));
        #1;
        check_val("start_busy", 32'(busy), 32'(0));
        check_val("start_rd", 32'(mem_rd), 32'(0));
        rd_hist.push_back(1'b0);
        idx_hist.push_back(0);

        for (int cyc = 1; cyc <= limit; cyc++) begin
            @(negedge clk);
            if (cut_kind != 0 && k == cut_after) begin
                start = 1'b0;
                stall = 1'b0;
                if (cut_kind == 1) begin
                    rst = 1'b1;
                    @(negedge clk);
                    rst = 1'b0;
                    #1;
                    check_val("rst_busy", 32'(busy), 32'(0));
                    $display("window base=0x%02h reset after %0d reads", base, k);
                    idle_check(LAT + 3, 1'b1, "post_rst");
                end
`ifdef WIN_CTRL_ABORT_EN
                else begin
                    abort = 1'b1;
                    #1;
                    check_val("abort_busy", 32'(busy), 32'(1));
                    @(negedge clk);
                    abort = 1'b0;
                    #1;
                    check_val("post_abort_busy", 32'(busy), 32'(0));
                    $display("window base=0x%02h aborted after %0d reads", base, k);
                    idle_check(LAT + 3, 1'b1, "post_abort");
                end
`endif
                return;
            end
            exp_done = (last_vld_cyc >= 0) && (cyc == last_vld_cyc + 1);
            start = pulse_start && (exp_done || ($urandom_range(0, 1) == 1));
            base_adr = ADR_W'($urandom);
            case (stall_mode)
                1:       stall = cyc[0];
                2:       stall = ($urandom_range(0, 3) == 0);
                default: stall = 1'b0;
            endcase
            #1;
            exp_rd = (k < NPIX) && !stall;
            check_val("mem_rd", 32'(mem_rd), 32'(exp_rd));
            if (exp_rd) check_val("mem_adr", 32'(mem_adr), 32'(exp_adr[k]));
            idx      = cyc - LAT;
            exp_vld  = (idx >= 0) ? rd_hist[idx] : 1'b0;
            exp_last = exp_vld && (idx_hist[idx] == NPIX - 1);
            check_val("pix_vld", 32'(pix_vld), 32'(exp_vld));
            check_val("pix_last", 32'(pix_last), 32'(exp_last));
            check_val("done", 32'(done), 32'(exp_done));
            check_val("busy", 32'(busy), 32'(1));
            rd_hist.push_back(exp_rd);
            idx_hist.push_back(k);
            if (exp_rd) k++;
            else if (k < NPIX) nstall++;
            if (exp_last) last_vld_cyc = cyc;
            if (exp_done) begin
                check_val("done_cycle", 32'(cyc), 32'(NPIX + LAT + 1 + nstall));
                $display("window base=0x%02h reads=%0d stalls=%0d done_cycle=%0d",
                         base, k, nstall, cyc);
                finished = 1'b1;
                break;
            end
        end
        if (!finished) check_val("timeout", 32'(0), 32'(1));
        idle_check(3, 1'b0, "after_done");
    endtask

    initial begin
        rst      = 1'b1;
        start    = 1'b0;
        stall    = 1'b0;
        base_adr = '0;
`ifdef WIN_CTRL_ABORT_EN
        abort    = 1'b0;
`endif
        repeat (3) @(negedge clk);
        #1;
        check_val("rst_busy", 32'(busy), 32'(0));
        check_val("rst_rd", 32'(mem_rd), 32'(0));
        check_val("rst_adr", 32'(mem_adr), 32'(0));
        check_val("rst_vld", 32'(pix_vld), 32'(0));
        check_val("rst_last", 32'(pix_last), 32'(0));
        check_val("rst_done", 32'(done), 32'(0));
        rst = 1'b0;
        idle_check(2, 1'b1, "idle");

        run_window(8'h00, 0, 1'b0, -1, 0);   // plain window from 0
        run_window(8'hF0, 0, 1'b0, -1, 0);   // wrapping addresses
        run_window(8'h35, 1, 1'b0, -1, 0);   // stall every other cycle
        run_window(8'h10, 0, 1'b0, 37, 1);   // reset mid-issue
        run_window(8'h22, 2, 1'b1, -1, 0);   // stray start pulses incl. DONE cycle
`ifdef WIN_CTRL_ABORT_EN
        run_window(8'h40, 0, 1'b0, 20, 2);   // abort mid-issue
        run_window(8'h41, 2, 1'b0, -1, 0);   // clean run after abort
`endif
        for (int i = 0; i < 4; i++) begin
            run_window(ADR_W'($urandom), $urandom_range(0, 2), 1'($urandom_range(0, 1)), -1, 0);
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
